pu_accum: RTL and testbench

Parametrised, pipelined multiply-accumulate processing unit; successor to the fixed 4-input, 5-bit PU. Takes N_CH signed input/weight pairs per beat, multiplies, reduces through a registered adder tree, and accumulates over a programmable number of beats with saturation. Applies an optional ReLU before presenting the result on a valid/ready output. It is the per-neuron compute element instantiated by the layer controller.

---
 rtl/pu_accum.sv | 162 ++++++++++++++++
 tb/tb_pu_accum.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_accum.sv
// Pipelined N_CH-lane signed MAC with saturating accumulation over a programmed beat count and optional ReLU.
// Last beat to out_valid is 4 cycles; in_ready drops once all beats are taken, and the result holds until out_ready.
module pu_accum #(
  parameter int N_CH    = 4,
  parameter int IN_W    = 5,
  parameter int W_W     = 5,
  parameter int ACC_W   = 16,
  parameter int BEATS_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BEATS_W-1:0]     num_beats,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*IN_W-1:0]   in_data,
  input  logic [N_CH*W_W-1:0]    weights,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   busy
);

  localparam int P_W = IN_W + W_W;
  localparam int LG  = $clog2(N_CH);
  localparam int S_W = P_W + LG;
  localparam int A1  = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [BEATS_W-1:0]        r_left;
  logic                      r_mode;
  logic                      r_in_rdy;
  logic                      r_busy;
  logic                      r_out_vld;
  logic [ACC_W-1:0]          r_out;

  logic signed [P_W-1:0]     r_prod [N_CH];
  logic                      r_p1_vld;
  logic signed [S_W-1:0]     r_sum;
  logic                      r_p2_vld;
  logic signed [ACC_W-1:0]   r_acc;

  logic                      w_accept;
  logic signed [P_W-1:0]     w_prod [N_CH];
  logic signed [S_W-1:0]     w_sum;
  logic signed [ACC_W:0]     w_acc_ext;
  logic signed [ACC_W-1:0]   w_acc_sat;

  assign w_accept  = in_valid & r_in_rdy;
  assign in_ready  = r_in_rdy;
  assign out_valid = r_out_vld;
  assign out_data  = r_out;
  assign busy      = r_busy;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_prod[i] = P_W'($signed(in_data[i*IN_W +: IN_W])) * P_W'($signed(weights[i*W_W +: W_W]));
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = w_sum + S_W'(r_prod[i]);
    end
  end

  // One guard bit above the accumulator detects overflow in either direction.
  always_comb begin
    w_acc_ext = A1'(r_acc) + A1'(r_sum);
    if (w_acc_ext[ACC_W] != w_acc_ext[ACC_W-1]) begin
      w_acc_sat = w_acc_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_acc_sat = w_acc_ext[ACC_W-1:0];
    end
  end

  // Idle cycles push zeros so a bubble can never disturb the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_prod[i] <= '0;
      end
      r_p1_vld <= 1'b0;
      r_sum    <= '0;
      r_p2_vld <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_prod[i] <= w_accept ? w_prod[i] : '0;
      end
      r_p1_vld <= w_accept;
      r_sum    <= r_p1_vld ? w_sum : '0;
      r_p2_vld <= r_p1_vld;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_left    <= '0;
      r_mode    <= 1'b0;
      r_in_rdy  <= 1'b0;
      r_busy    <= 1'b0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
      r_acc     <= '0;
    end else begin
      if (r_p2_vld) begin
        r_acc <= w_acc_sat;
      end
      case (r_state)
        S_IDLE: begin
          if (start && num_beats != '0) begin
            r_left   <= num_beats;
            r_mode   <= mode;
            r_acc    <= '0;
            r_in_rdy <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_left <= r_left - BEATS_W'(1);
            if (r_left == BEATS_W'(1)) begin
              r_in_rdy <= 1'b0;
              r_state  <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Both stage valids low means the last sum has already landed in r_acc.
          if (!r_p1_vld && !r_p2_vld) begin
            r_out     <= (r_mode && r_acc[ACC_W-1]) ? '0 : r_acc;
            r_out_vld <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_accum.sv
// Bench for pu_accum: two instances (ACC_W 16 and 12) share stimulus and are checked against a beat-level model.
module tb_pu_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_beats = '0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data = '0;
  logic [19:0] weights = '0;
  logic        out_ready = 1'b0;

  logic        ird0, ovl0, bsy0;
  logic        ird1, ovl1, bsy1;
  logic [15:0] od0;
  logic [11:0] od1;

  int nchk  = 0;
  int nfail = 0;
  int exp16 = 0;
  int exp12 = 0;
  logic [19:0] q_d[$];
  logic [19:0] q_w[$];

  always #5 clk = ~clk;

  pu_accum #(.N_CH(4), .IN_W(5), .W_W(5), .ACC_W(16), .BEATS_W(4)) u_d16 (
    .clk(clk), .rst(rst), .start(start), .num_beats(num_beats), .mode(mode),
    .in_valid(in_valid), .in_ready(ird0), .in_data(in_data), .weights(weights),
    .out_valid(ovl0), .out_ready(out_ready), .out_data(od0), .busy(bsy0)
  );

  pu_accum #(.N_CH(4), .IN_W(5), .W_W(5), .ACC_W(12), .BEATS_W(4)) u_d12 (
    .clk(clk), .rst(rst), .start(start), .num_beats(num_beats), .mode(mode),
    .in_valid(in_valid), .in_ready(ird1), .in_data(in_data), .weights(weights),
    .out_valid(ovl1), .out_ready(out_ready), .out_data(od1), .busy(bsy1)
  );

  task automatic chk(input string nm, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = 1 << (w - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
    logic [19:0] r;
    r = {d[4:0], c[4:0], b[4:0], a[4:0]};
    return r;
  endfunction

  // Reference: dot product per beat, clamp after every beat, ReLU at the end.
  task automatic model(input bit md);
    int a16, a12, dot;
    logic [19:0] dd, ww;
    a16 = 0;
    a12 = 0;
    for (int b = 0; b < q_d.size(); b++) begin
      dd  = q_d[b];
      ww  = q_w[b];
      dot = 0;
      for (int i = 0; i < 4; i++) begin
        dot += int'($signed(dd[i*5 +: 5])) * int'($signed(ww[i*5 +: 5]));
      end
      a16 = sat(a16 + dot, 16);
      a12 = sat(a12 + dot, 12);
    end
    if (md && a16 < 0) a16 = 0;
    if (md && a12 < 0) a12 = 0;
    exp16 = a16;
    exp12 = a12;
  endtask

  task automatic fill_const(input int n, input logic [19:0] d, input logic [19:0] w);
    q_d.delete();
    q_w.delete();
    for (int i = 0; i < n; i++) begin
      q_d.push_back(d);
      q_w.push_back(w);
    end
  endtask

  task automatic fill_rand(input int n);
    q_d.delete();
    q_w.delete();
    for (int i = 0; i < n; i++) begin
      q_d.push_back(20'($urandom));
      q_w.push_back(20'($urandom));
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the output handshake.
  task automatic run_job(input int n, input bit md, input int gap_mode, input int hold,
                         input bit use_lit, input int l16, input int l12);
    int  taken, cyc, gc;
    bit  v;
    taken = 0;
    cyc   = 0;
    gc    = 0;
    model(md);
    if (use_lit) begin
      chk("model16", exp16, l16);
      chk("model12", exp12, l12);
    end
    chk("idle_busy16", int'(bsy0), 0);
    chk("idle_busy12", int'(bsy1), 0);
    start     = 1'b1;
    num_beats = 4'(n);
    mode      = md;
    @(negedge clk);
    start = 1'b0;
    mode  = ~md;
    chk("ird_rise16", int'(ird0), 1);
    chk("ird_rise12", int'(ird1), 1);
    chk("busy_rise16", int'(bsy0), 1);
    chk("busy_rise12", int'(bsy1), 1);
    while (taken < n && cyc < 300) begin
      case (gap_mode)
        0: v = 1'b1;
        1: v = ($urandom_range(0, 99) >= 30);
        default: begin
          v = (gc == 0);
          if (!v) gc--;
        end
      endcase
      in_valid = v;
      in_data  = v ? q_d[taken] : 20'($urandom);
      weights  = v ? q_w[taken] : 20'($urandom);
      if (v && ird0) begin
        taken++;
        if (gap_mode == 2) gc = 2;
      end
      @(negedge clk);
      cyc++;
    end
    chk("beats_taken", taken, n);
    in_valid = 1'b1;
    in_data  = 20'($urandom);
    weights  = 20'($urandom);
    chk("ird_fall16", int'(ird0), 0);
    chk("ird_fall12", int'(ird1), 0);
    for (int k = 1; k <= 4; k++) begin
      chk("ovl_lat16", int'(ovl0), int'(k == 4));
      chk("ovl_lat12", int'(ovl1), int'(k == 4));
      if (k < 4) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    if (use_lit) begin
      chk("lit16", int'($signed(od0)), l16);
      chk("lit12", int'($signed(od1)), l12);
    end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = (h == 1);
      num_beats = 4'd3;
      @(negedge clk);
      chk("hold_ovl16", int'(ovl0), 1);
      chk("hold_ovl12", int'(ovl1), 1);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_ovl16", int'(ovl0), 0);
    chk("post_ovl12", int'(ovl1), 0);
    chk("post_busy16", int'(bsy0), 0);
    chk("post_busy12", int'(bsy1), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (ovl0) begin
        chk("out16", int'($signed(od0)), exp16);
        chk("done_ird16", int'(ird0), 0);
        chk("done_busy16", int'(bsy0), 1);
      end
      if (ovl1) begin
        chk("out12", int'($signed(od1)), exp12);
        chk("done_ird12", int'(ird1), 0);
        chk("done_busy12", int'(bsy1), 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ird16", int'(ird0), 0);
    chk("rst_ovl16", int'(ovl0), 0);
    chk("rst_busy16", int'(bsy0), 0);
    chk("rst_out16", int'(od0), 0);
    chk("rst_ird12", int'(ird1), 0);
    chk("rst_ovl12", int'(ovl1), 0);
    chk("rst_busy12", int'(bsy1), 0);
    chk("rst_out12", int'(od1), 0);
    rst = 1'b1;
    @(negedge clk);

    start     = 1'b1;
    num_beats = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_start_busy", int'(bsy0), 0);
    chk("zero_start_ird", int'(ird0), 0);
    @(negedge clk);
    chk("zero_start_busy2", int'(bsy1), 0);

    q_d.delete(); q_w.delete();
    q_d.push_back(pack4(3, 4, 5, 6));
    q_w.push_back(pack4(1, 2, 3, -1));
    run_job(1, 1'b0, 0, 0, 1'b1, 20, 20);

    fill_const(3, pack4(15, 15, 15, 15), pack4(15, 15, 15, 15));
    run_job(3, 1'b0, 2, 1, 1'b1, 2700, 2047);

    fill_const(1, pack4(1, 1, 1, 1), pack4(-1, -1, -1, -1));
    run_job(1, 1'b0, 0, 0, 1'b1, -4, -4);
    run_job(1, 1'b1, 0, 0, 1'b1, 0, 0);

    fill_const(3, pack4(-16, -16, -16, -16), pack4(-16, -16, -16, -16));
    run_job(3, 1'b0, 0, 0, 1'b1, 3072, 2047);

    q_d.delete(); q_w.delete();
    q_d.push_back(pack4(3, 4, 5, 6));
    q_w.push_back(pack4(1, 2, 3, -1));
    run_job(1, 1'b0, 0, 5, 1'b1, 20, 20);

    fill_const(15, pack4(-16, -16, -16, -16), pack4(-16, -16, -16, -16));
    run_job(15, 1'b0, 1, 2, 1'b1, 15360, 2047);

    fill_const(4, pack4(15, 15, 15, 15), pack4(15, 15, 15, 15));
    start     = 1'b1;
    num_beats = 4'd4;
    mode      = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = q_d[0];
    weights  = q_w[0];
    @(negedge clk);
    in_data = q_d[1];
    weights = q_w[1];
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_ird16", int'(ird0), 0);
    chk("arst_ovl16", int'(ovl0), 0);
    chk("arst_busy16", int'(bsy0), 0);
    chk("arst_out16", int'(od0), 0);
    chk("arst_ird12", int'(ird1), 0);
    chk("arst_busy12", int'(bsy1), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q_d.delete(); q_w.delete();
    q_d.push_back(pack4(2, 0, 0, 0));
    q_w.push_back(pack4(3, 0, 0, 0));
    run_job(1, 1'b0, 0, 0, 1'b1, 6, 6);

    for (int j = 0; j < 20; j++) begin
      int n;
      n = $urandom_range(1, 15);
      fill_rand(n);
      run_job(n, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 0, 0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
